// File: rtl/rand_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rand_share_ctrl                                                  |
// | Purpose  : Round-robin sharing of one LFSR random source between requesters |
// |            with range check and bounded redraw. Optional idle stirring is   |
// |            enabled by defining RAND_STIR_EN.                                |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rand_share_ctrl #(
    parameter int N_REQ       = 2,
    parameter int RAND_W      = 4,
    parameter int MAX_RETRY   = 3,
    parameter int STIR_PERIOD = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*RAND_W-1:0] i_max,
    input  logic [RAND_W-1:0]       i_random,
    output logic                    o_lfsr_enable,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [N_REQ-1:0]        o_valid,
    output logic [RAND_W-1:0]       o_data,
    output logic                    o_busy
);

    localparam int c_idx_w   = $clog2(N_REQ);
    localparam int c_retry_w = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [N_REQ-1:0] c_one = {{(N_REQ-1){1'b0}}, 1'b1};
`ifdef RAND_STIR_EN
    localparam int c_stir_w  = $clog2(STIR_PERIOD);
`endif

    if (N_REQ < 2 || N_REQ > 8 || RAND_W < 1 || MAX_RETRY < 0 || STIR_PERIOD < 2) begin : g_bad_param
        $error("rand_share_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PULSE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
`ifdef RAND_STIR_EN
        ,
        S_STIR_HI = 3'd5,
        S_STIR_LO = 3'd6
`endif
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_en, w_en_nxt;
    logic [N_REQ-1:0]     r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0]     r_valid, w_valid_nxt;
    logic [RAND_W-1:0]    r_data, w_data_nxt;
    logic                 r_busy;
    logic [c_idx_w-1:0]   r_idx, w_idx_nxt;
    logic [c_idx_w-1:0]   r_rr_ptr, w_rr_nxt;
    logic [RAND_W-1:0]    r_max, w_max_nxt;
    logic [c_retry_w-1:0] r_retry, w_retry_nxt;
    logic                 w_found;
    logic [c_idx_w-1:0]   w_pick;
`ifdef RAND_STIR_EN
    logic [c_stir_w-1:0]  r_stir_cnt, w_stir_nxt;
`endif

    function automatic logic [c_idx_w-1:0] rr_index(input logic [c_idx_w-1:0] ptr, input int k);
        int j;
        j = int'(ptr) + 1 + k;
        if (j >= N_REQ) j = j - N_REQ;
        return c_idx_w'(j);
    endfunction

    // First requester after the last one served, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && i_req[rr_index(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = rr_index(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_gnt_nxt   = r_gnt;
        w_valid_nxt = '0;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        w_rr_nxt    = r_rr_ptr;
        w_max_nxt   = r_max;
        w_retry_nxt = r_retry;
`ifdef RAND_STIR_EN
        w_stir_nxt  = r_stir_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_PULSE;
                    w_en_nxt    = 1'b1;
                    w_gnt_nxt   = c_one << w_pick;
                    w_idx_nxt   = w_pick;
                    w_max_nxt   = i_max[int'(w_pick)*RAND_W +: RAND_W];
`ifdef RAND_STIR_EN
                    w_stir_nxt  = '0;
                end else if (int'(r_stir_cnt) == STIR_PERIOD - 1) begin
                    w_state_nxt = S_STIR_HI;
                    w_en_nxt    = 1'b1;
                    w_stir_nxt  = '0;
                end else begin
                    w_stir_nxt  = r_stir_cnt + 1'b1;
`else
                end else begin
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            S_PULSE:  w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                if (i_random <= r_max) begin
                    w_data_nxt  = i_random;
                    w_valid_nxt = c_one << r_idx;
                    w_state_nxt = S_DONE;
                end else if (int'(r_retry) < MAX_RETRY) begin
                    w_retry_nxt = r_retry + 1'b1;
                    w_en_nxt    = 1'b1;
                    w_state_nxt = S_PULSE;
                end else begin
                    w_data_nxt  = (i_random < r_max) ? i_random : r_max;
                    w_valid_nxt = c_one << r_idx;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_gnt_nxt   = '0;
                w_rr_nxt    = r_idx;
                w_retry_nxt = '0;
                w_state_nxt = S_IDLE;
            end
`ifdef RAND_STIR_EN
            S_STIR_HI: w_state_nxt = S_STIR_LO;
            S_STIR_LO: w_state_nxt = S_IDLE;
`endif
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_en       <= 1'b0;
            r_gnt      <= '0;
            r_valid    <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_idx      <= '0;
            r_rr_ptr   <= c_idx_w'(N_REQ - 1);
            r_max      <= '0;
            r_retry    <= '0;
`ifdef RAND_STIR_EN
            r_stir_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_en       <= w_en_nxt;
            r_gnt      <= w_gnt_nxt;
            r_valid    <= w_valid_nxt;
            r_data     <= w_data_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_idx      <= w_idx_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_max      <= w_max_nxt;
            r_retry    <= w_retry_nxt;
`ifdef RAND_STIR_EN
            r_stir_cnt <= w_stir_nxt;
`endif
        end
    end

    assign o_lfsr_enable = r_en;
    assign o_gnt         = r_gnt;
    assign o_valid       = r_valid;
    assign o_data        = r_data;
    assign o_busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rand_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rand_share_ctrl                                               |
// | Purpose  : Scoreboard bench for rand_share_ctrl driving a 4-bit LFSR model. |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_rand_share_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [7:0] maxv = '0;
    logic [3:0] lfsr_q = 4'd3;
    logic       lfsr_en;
    logic [1:0] gnt, valid;
    logic [3:0] data;
    logic       busy;
    logic       prev_en = 1'b0;

    typedef struct {
        int         idx;
        logic [3:0] data;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    rand_share_ctrl #(
        .N_REQ(2), .RAND_W(4), .MAX_RETRY(3), .STIR_PERIOD(16)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_max(maxv), .i_random(lfsr_q),
        .o_lfsr_enable(lfsr_en), .o_gnt(gnt), .o_valid(valid), .o_data(data), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Sequence from seed 3: 9,4,2,1,8,12,14,15,7,11,5,10,13,6,3
    always @(posedge lfsr_en) lfsr_q <= {lfsr_q[0] ^ lfsr_q[3], lfsr_q[3:1]};

    function automatic logic [3:0] lfsr_next(input logic [3:0] v);
        return {v[0] ^ v[3], v[3:1]};
    endfunction

    always @(negedge clk) begin
        if (lfsr_en && prev_en) begin
            errors++;
            $display("FAIL en_consecutive: enable high two cycles, got 1 want 0");
        end
        prev_en <= lfsr_en;
        if (valid != 2'b00) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got valid=%b data=%0d want no valid", valid, data);
            end else begin
                exp_t e;
                logic [1:0] ev;
                e  = sb_q.pop_front();
                ev = 2'b01 << e.idx;
                if (valid !== ev || data !== e.data || gnt !== ev) begin
                    errors++;
                    $display("FAIL result: got valid=%b gnt=%b data=%0d want valid=%b gnt=%b data=%0d",
                             valid, gnt, data, ev, ev, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Called at a negedge; that cycle is cycle 0 of the transaction.
    task automatic txn(input int idx, input logic [3:0] mx, input logic [3:0] exp_d,
                       input int exp_lat, input int exp_pulses);
        int cyc, pulses, first_gnt, first_en;
        bit got;
        maxv[idx*4 +: 4] = mx;
        req[idx] = 1'b1;
        sb_q.push_back('{idx, exp_d});
        cyc = 0; pulses = 0; first_gnt = -1; first_en = -1; got = 0;
        while (cyc < 30 && !got) begin
            @(negedge clk);
            cyc++;
            if (lfsr_en) begin
                pulses++;
                if (first_en < 0) first_en = cyc;
            end
            if (first_gnt < 0 && gnt != 2'b00) first_gnt = cyc;
            if (valid[idx]) got = 1;
        end
        req[idx] = 1'b0;
        chk("latency", got ? cyc : -1, exp_lat);
        chk("enable_pulses", pulses, exp_pulses);
        chk("first_grant_cycle", first_gnt, 1);
        chk("first_enable_cycle", first_en, 1);
        @(negedge clk);
        chk("idle_after_done", {busy, gnt}, 0);
    endtask

    initial begin
        int cyc, k, t0;
        @(negedge clk);
        chk("reset_outputs", {lfsr_en, gnt, valid, data, busy}, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1..3: single requests, in-range, one redraw, full fallback
        txn(0, 4'd15, 4'd9, 4, 1);
        txn(1, 4'd3, 4'd2, 7, 2);
        txn(0, 4'd0, 4'd0, 13, 4);

        // 4: both held after reset -> alternate 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        maxv = 8'hFF;
        sb_q.push_back('{0, 4'd15});
        sb_q.push_back('{1, 4'd7});
        sb_q.push_back('{0, 4'd11});
        sb_q.push_back('{1, 4'd5});
        req = 2'b11;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            chk("single_grant", ($countones(gnt) > 1) ? 1 : 0, 0);
            if (valid != 2'b00) begin
                k++;
                if (k == 4) req = 2'b00;
            end
        end
        chk("alternating_served", k, 4);
        @(negedge clk);

        // 5: reset during PULSE aborts, pending request then served
        maxv[3:0] = 4'd15;
        req[0] = 1'b1;
        @(negedge clk);
        chk("pulse_before_reset", {lfsr_en, gnt}, 3'b101);
        #1 rst = 1'b1;
        #1 chk("outputs_in_reset", {lfsr_en, gnt, valid, busy}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        txn(0, 4'd15, 4'd13, 4, 1);

`ifdef RAND_STIR_EN
        // 6: idle stirring every STIR_PERIOD+2 cycles, request during stir
        cyc = 0;
        while (cyc < 40 && !lfsr_en) begin @(negedge clk); cyc++; end
        t0 = cyc;
        @(negedge clk); cyc++;
        while (cyc < 80 && !lfsr_en) begin @(negedge clk); cyc++; end
        chk("stir_period", cyc - t0, 18);
        chk("stir_no_grant", {gnt, valid}, 0);
        chk("stir_busy", busy, 1);
        maxv[3:0] = 4'd15;
        req[0] = 1'b1;
        sb_q.push_back('{0, lfsr_next(lfsr_q)});
        @(negedge clk);
        @(negedge clk);
        chk("no_grant_in_idle", gnt, 0);
        @(negedge clk);
        chk("grant_after_stir", gnt, 1);
        cyc = 0;
        while (cyc < 20 && valid == 2'b00) begin @(negedge clk); cyc++; end
        chk("stir_req_served", valid, 1);
        req[0] = 1'b0;
        @(negedge clk);
`else
        // Without stirring, idle produces no enable pulses at all.
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lfsr_en) k++;
        end
        chk("idle_no_enable", k, 0);
        t0 = 0;
`endif
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
